// File: rtl/tl_memory_pkg.sv
// Shared MIPS memory-stage definitions: access-size codes, MEM control bit
// positions, default data-memory depth and the alignment rule.
package tl_memory_pkg;

    localparam int unsigned N_WORDS_DEFAULT = 128;

    // i_mem_size encodings; the reserved code behaves as a word access
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
    localparam logic [1:0] MEM_SIZE_RSVD = 2'b11;

    // Bit positions inside the {Branch, MemRead, MemWrite} control bundle
    localparam int unsigned CTRL_MEM_BRANCH = 2;
    localparam int unsigned CTRL_MEM_READ   = 1;
    localparam int unsigned CTRL_MEM_WRITE  = 0;

    // True when an access of the given size cannot start at this byte offset
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            MEM_SIZE_BYTE: bad = 1'b0;
            MEM_SIZE_HALF: bad = off[0];
            default:       bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory with per-byte write enables.
// Ports: i_clk; i_we/i_be/i_idx/i_wdata write port (lane-positioned data);
// o_rdata_c combinational read of word i_idx (pre-write value on a write edge).
// Optional MEM_DEBUG_PORT_EN: i_dbg_addr / o_dbg_data combinational debug read.
// Contents are never reset.
module data_memory
    import tl_memory_pkg::*;
#(
    parameter int unsigned LEN     = 32,
    parameter int unsigned N_WORDS = N_WORDS_DEFAULT,
    localparam int unsigned NB_IDX   = $clog2(N_WORDS),
    localparam int unsigned NB_LANES = LEN / 8
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [NB_LANES-1:0] i_be,
    input  logic [NB_IDX-1:0]   i_idx,
    input  logic [LEN-1:0]      i_wdata,
    output logic [LEN-1:0]      o_rdata_c
`ifdef MEM_DEBUG_PORT_EN
    ,
    input  logic [NB_IDX-1:0]   i_dbg_addr,
    output logic [LEN-1:0]      o_dbg_data
`endif
);

    logic [LEN-1:0] mem_q [N_WORDS];
    logic [LEN-1:0] word_d;

    // Merge enabled byte lanes into the currently stored word
    always_comb begin
        word_d = mem_q[i_idx];
        for (int i = 0; i < int'(NB_LANES); i++) begin
            if (i_be[i]) begin
                word_d[8*i +: 8] = i_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_idx] <= word_d;
        end
    end

    assign o_rdata_c = mem_q[i_idx];

`ifdef MEM_DEBUG_PORT_EN
    assign o_dbg_data = mem_q[i_dbg_addr];
`endif

endmodule

// File: rtl/tl_memory.sv
// MIPS MEM pipeline stage: data-memory access with byte/half/word lanes,
// load extension, alignment checking and the MEM/WB pipeline register.
// Ports: i_clk, i_rst (async active-low), i_enable (stage advance);
// execute-stage inputs i_alu_result/i_dato2/i_add_execute/i_alu_zero,
// controls i_ctrl_wb/i_ctrl_mem/i_mem_size/i_mem_unsigned/i_write_reg;
// registered o_read_data/o_alu_result/o_write_reg/o_ctrl_wb/o_misaligned;
// combinational o_pc_src/o_branch_addr.
// Optional MEM_DEBUG_PORT_EN adds i_dbg_addr/o_dbg_data word read for the debug unit.
module tl_memory
    import tl_memory_pkg::*;
#(
    parameter int unsigned LEN                  = 32,
    parameter int unsigned NB_ADDRESS_REGISTROS = 5,
    parameter int unsigned NB_CTRL_WB           = 2,
    parameter int unsigned NB_CTRL_MEM          = 3,
    parameter int unsigned N_WORDS              = N_WORDS_DEFAULT,
    localparam int unsigned NB_IDX              = $clog2(N_WORDS)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_enable,
    input  logic [LEN-1:0]                  i_alu_result,
    input  logic [LEN-1:0]                  i_dato2,
    input  logic [LEN-1:0]                  i_add_execute,
    input  logic                            i_alu_zero,
    input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
    input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
    input  logic [1:0]                      i_mem_size,
    input  logic                            i_mem_unsigned,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
    output logic [LEN-1:0]                  o_read_data,
    output logic [LEN-1:0]                  o_alu_result,
    output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
    output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
    output logic                            o_pc_src,
    output logic [LEN-1:0]                  o_branch_addr,
    output logic                            o_misaligned
`ifdef MEM_DEBUG_PORT_EN
    ,
    input  logic [NB_IDX-1:0]               i_dbg_addr,
    output logic [LEN-1:0]                  o_dbg_data
`endif
);

    localparam int unsigned NB_LANES = LEN / 8;
    localparam int unsigned NB_OFF   = $clog2(NB_LANES);

    logic [NB_OFF-1:0]   byte_off;
    logic [NB_IDX-1:0]   word_idx;
    logic                mem_read;
    logic                mem_write;
    logic                size_misaligned;
    logic                mem_we;
    logic [NB_LANES-1:0] mem_be;
    logic [LEN-1:0]      mem_wdata;
    logic [LEN-1:0]      mem_rdata_c;
    logic [LEN-1:0]      lane_word;
    logic [LEN-1:0]      load_ext;

    logic [LEN-1:0]                  read_data_d,  read_data_q;
    logic [LEN-1:0]                  alu_result_d, alu_result_q;
    logic [NB_ADDRESS_REGISTROS-1:0] write_reg_d,  write_reg_q;
    logic [NB_CTRL_WB-1:0]           ctrl_wb_d,    ctrl_wb_q;
    logic                            misaligned_d, misaligned_q;

    assign byte_off        = i_alu_result[NB_OFF-1:0];
    assign word_idx        = i_alu_result[NB_IDX+NB_OFF-1:NB_OFF];
    assign mem_read        = i_ctrl_mem[CTRL_MEM_READ];
    assign mem_write       = i_ctrl_mem[CTRL_MEM_WRITE];
    assign size_misaligned = is_misaligned(i_mem_size, byte_off);

    // Branch resolution bypasses the pipeline register entirely
    assign o_pc_src      = i_ctrl_mem[CTRL_MEM_BRANCH] & i_alu_zero;
    assign o_branch_addr = i_add_execute;

    // Reset level gates the write so a store on a reset edge is dropped
    assign mem_we = i_rst & i_enable & mem_write & ~size_misaligned;

    // Replicate store data across lanes and enable only the addressed ones
    always_comb begin
        mem_be    = '1;
        mem_wdata = i_dato2;
        case (i_mem_size)
            MEM_SIZE_BYTE: begin
                mem_be    = NB_LANES'(1) << byte_off;
                mem_wdata = {NB_LANES{i_dato2[7:0]}};
            end
            MEM_SIZE_HALF: begin
                mem_be    = NB_LANES'(3) << {byte_off[NB_OFF-1:1], 1'b0};
                mem_wdata = {(NB_LANES/2){i_dato2[15:0]}};
            end
            default: begin
                mem_be    = '1;
                mem_wdata = i_dato2;
            end
        endcase
    end

    // Bring the addressed lane to bit 0, then sign- or zero-extend
    always_comb begin
        lane_word = mem_rdata_c >> {byte_off, 3'b000};
        load_ext  = mem_rdata_c;
        case (i_mem_size)
            MEM_SIZE_BYTE: load_ext = i_mem_unsigned ? {{(LEN-8){1'b0}}, lane_word[7:0]}
                                                     : {{(LEN-8){lane_word[7]}}, lane_word[7:0]};
            MEM_SIZE_HALF: load_ext = i_mem_unsigned ? {{(LEN-16){1'b0}}, lane_word[15:0]}
                                                     : {{(LEN-16){lane_word[15]}}, lane_word[15:0]};
            default:       load_ext = mem_rdata_c;
        endcase
    end

    // MEM/WB register next state; everything holds while the stage is stalled
    always_comb begin
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        write_reg_d  = write_reg_q;
        ctrl_wb_d    = ctrl_wb_q;
        misaligned_d = misaligned_q;
        if (i_enable) begin
            alu_result_d = i_alu_result;
            write_reg_d  = i_write_reg;
            ctrl_wb_d    = i_ctrl_wb;
            read_data_d  = (mem_read && !size_misaligned) ? load_ext : '0;
            misaligned_d = misaligned_q | ((mem_read | mem_write) & size_misaligned);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            read_data_q  <= '0;
            alu_result_q <= '0;
            write_reg_q  <= '0;
            ctrl_wb_q    <= '0;
            misaligned_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            write_reg_q  <= write_reg_d;
            ctrl_wb_q    <= ctrl_wb_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign o_read_data  = read_data_q;
    assign o_alu_result = alu_result_q;
    assign o_write_reg  = write_reg_q;
    assign o_ctrl_wb    = ctrl_wb_q;
    assign o_misaligned = misaligned_q;

    data_memory #(
        .LEN     (LEN),
        .N_WORDS (N_WORDS)
    ) u_data_memory (
        .i_clk      (i_clk),
        .i_we       (mem_we),
        .i_be       (mem_be),
        .i_idx      (word_idx),
        .i_wdata    (mem_wdata),
        .o_rdata_c  (mem_rdata_c)
`ifdef MEM_DEBUG_PORT_EN
        ,
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data)
`endif
    );

endmodule

// File: tb/tb_tl_memory.sv
// Directed bench for tl_memory: stimulus pushes hand-computed expectations
// into a scoreboard queue, a monitor pops one entry per clock and compares.
module tb_tl_memory;

    logic        i_clk;
    logic        i_rst;
    logic        i_enable;
    logic [31:0] i_alu_result;
    logic [31:0] i_dato2;
    logic [31:0] i_add_execute;
    logic        i_alu_zero;
    logic [1:0]  i_ctrl_wb;
    logic [2:0]  i_ctrl_mem;
    logic [1:0]  i_mem_size;
    logic        i_mem_unsigned;
    logic [4:0]  i_write_reg;
    logic [31:0] o_read_data;
    logic [31:0] o_alu_result;
    logic [4:0]  o_write_reg;
    logic [1:0]  o_ctrl_wb;
    logic        o_pc_src;
    logic [31:0] o_branch_addr;
    logic        o_misaligned;
`ifdef MEM_DEBUG_PORT_EN
    logic [6:0]  i_dbg_addr;
    logic [31:0] o_dbg_data;
`endif

    tl_memory dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_enable       (i_enable),
        .i_alu_result   (i_alu_result),
        .i_dato2        (i_dato2),
        .i_add_execute  (i_add_execute),
        .i_alu_zero     (i_alu_zero),
        .i_ctrl_wb      (i_ctrl_wb),
        .i_ctrl_mem     (i_ctrl_mem),
        .i_mem_size     (i_mem_size),
        .i_mem_unsigned (i_mem_unsigned),
        .i_write_reg    (i_write_reg),
        .o_read_data    (o_read_data),
        .o_alu_result   (o_alu_result),
        .o_write_reg    (o_write_reg),
        .o_ctrl_wb      (o_ctrl_wb),
        .o_pc_src       (o_pc_src),
        .o_branch_addr  (o_branch_addr),
        .o_misaligned   (o_misaligned)
`ifdef MEM_DEBUG_PORT_EN
        ,
        .i_dbg_addr     (i_dbg_addr),
        .o_dbg_data     (o_dbg_data)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int          id;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [1:0]  wb;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    // Expected state of the registered outputs
    logic [31:0] m_rd, m_alu;
    logic [4:0]  m_wr;
    logic [1:0]  m_wb;
    logic        m_mis;

    localparam logic [2:0] CM_NONE = 3'b000;
    localparam logic [2:0] CM_WR   = 3'b001;
    localparam logic [2:0] CM_RD   = 3'b010;
    localparam logic [2:0] CM_RW   = 3'b011;
    localparam logic [2:0] CM_BR   = 3'b100;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec%0d actual=%h required=%h", name, id, act, exp);
        end
    endtask

    task automatic chk_zero(input int id);
        chk("rst_read_data",  id, o_read_data, 32'h0);
        chk("rst_alu_result", id, o_alu_result, 32'h0);
        chk("rst_write_reg",  id, 32'(o_write_reg), 32'h0);
        chk("rst_ctrl_wb",    id, 32'(o_ctrl_wb), 32'h0);
        chk("rst_misaligned", id, 32'(o_misaligned), 32'h0);
    endtask

    // Issue one stage transaction and queue what the register must show after the edge
    task automatic drive(input bit en, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] cm, input logic [1:0] sz, input bit uns,
                         input logic [31:0] exp_rd, input bit exp_mis);
        exp_t e;
        @(negedge i_clk);
        vec_id++;
        i_enable       = en;
        i_alu_result   = addr;
        i_dato2        = data;
        i_ctrl_mem     = cm;
        i_mem_size     = sz;
        i_mem_unsigned = uns;
        i_write_reg    = 5'(vec_id);
        i_ctrl_wb      = 2'(vec_id);
        if (en) begin
            m_rd  = exp_rd;
            m_alu = addr;
            m_wr  = 5'(vec_id);
            m_wb  = 2'(vec_id);
            m_mis = exp_mis;
        end
        e.id  = vec_id;
        e.rd  = m_rd;
        e.alu = m_alu;
        e.wr  = m_wr;
        e.wb  = m_wb;
        e.mis = m_mis;
        sb_q.push_back(e);
    endtask

    // Monitor: the register updates every edge, so one entry is consumed per edge
    always @(posedge i_clk) begin
        exp_t e;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("read_data",  e.id, o_read_data, e.rd);
            chk("alu_result", e.id, o_alu_result, e.alu);
            chk("write_reg",  e.id, 32'(o_write_reg), 32'(e.wr));
            chk("ctrl_wb",    e.id, 32'(o_ctrl_wb), 32'(e.wb));
            chk("misaligned", e.id, 32'(o_misaligned), 32'(e.mis));
        end
    end

    task automatic drain;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge i_clk);
        repeat (1) @(posedge i_clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
    endtask

    initial begin
        i_rst = 1'b0; i_enable = 1'b0; i_alu_result = '0; i_dato2 = '0;
        i_add_execute = '0; i_alu_zero = 1'b0; i_ctrl_wb = '0; i_ctrl_mem = '0;
        i_mem_size = 2'b10; i_mem_unsigned = 1'b0; i_write_reg = '0;
`ifdef MEM_DEBUG_PORT_EN
        i_dbg_addr = '0;
`endif
        m_rd = '0; m_alu = '0; m_wr = '0; m_wb = '0; m_mis = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 chk_zero(0);
        @(negedge i_clk);
        i_rst = 1'b1;

        //     en  addr          data          cm       size   uns  exp_rd        mis
        drive(1, 32'h10, 32'hDEADBEEF, CM_WR,   2'b10, 0, 32'h0,        0);
        drive(1, 32'h10, 32'h0,        CM_RD,   2'b10, 0, 32'hDEADBEEF, 0);
        drive(1, 32'h13, 32'h0,        CM_RD,   2'b00, 0, 32'hFFFFFFDE, 0);
        drive(1, 32'h13, 32'h0,        CM_RD,   2'b00, 1, 32'h000000DE, 0);
        drive(1, 32'h12, 32'h0,        CM_RD,   2'b01, 0, 32'hFFFFDEAD, 0);
        drive(1, 32'h10, 32'h0,        CM_RD,   2'b01, 1, 32'h0000BEEF, 0);
        drive(1, 32'h10, 32'h0,        CM_RD,   2'b00, 0, 32'hFFFFFFEF, 0);
        drive(1, 32'h11, 32'h12345655, CM_WR,   2'b00, 0, 32'h0,        0);
        drive(1, 32'h10, 32'h0,        CM_RD,   2'b10, 0, 32'hDEAD55EF, 0);
        drive(1, 32'h11, 32'h00001234, CM_WR,   2'b01, 0, 32'h0,        1);
        drive(1, 32'h10, 32'h0,        CM_RD,   2'b10, 0, 32'hDEAD55EF, 1);
        drive(1, 32'h12, 32'h0,        CM_RD,   2'b10, 0, 32'h0,        1);
        drive(1, 32'h20, 32'h0000CAFE, CM_WR,   2'b10, 0, 32'h0,        1);
        drive(1, 32'h20, 32'hA5A5A5A5, CM_RW,   2'b10, 0, 32'h0000CAFE, 1);
        drive(1, 32'h20, 32'h0,        CM_RD,   2'b10, 0, 32'hA5A5A5A5, 1);
        drive(0, 32'h20, 32'h5,        CM_WR,   2'b10, 0, 32'h0,        1);
        drive(1, 32'h20, 32'h0,        CM_RD,   2'b10, 0, 32'hA5A5A5A5, 1);
        drive(1, 32'h24, 32'h11223344, CM_WR,   2'b11, 0, 32'h0,        1);
        drive(1, 32'h26, 32'hFFFFBEEF, CM_WR,   2'b01, 0, 32'h0,        1);
        drive(1, 32'h24, 32'h0,        CM_RD,   2'b10, 0, 32'hBEEF3344, 1);
        drive(1, 32'h26, 32'h0,        CM_RD,   2'b01, 1, 32'h0000BEEF, 1);
        drive(1, 32'h24, 32'h0,        CM_RD,   2'b01, 0, 32'h00003344, 1);
        drive(1, 32'h24, 32'h0,        CM_NONE, 2'b10, 0, 32'h0,        1);

        // Branch outputs are combinational and ignore the stall
        @(negedge i_clk);
        i_enable = 1'b0; i_ctrl_mem = CM_BR; i_alu_zero = 1'b1; i_add_execute = 32'h40;
        #1;
        chk("pc_src_taken", 100, 32'(o_pc_src), 32'h1);
        chk("branch_addr",  100, o_branch_addr, 32'h40);
        i_alu_zero = 1'b0; i_add_execute = 32'h1234_5678;
        #1;
        chk("pc_src_zero0", 101, 32'(o_pc_src), 32'h0);
        chk("branch_addr2", 101, o_branch_addr, 32'h1234_5678);
        i_ctrl_mem = CM_NONE; i_alu_zero = 1'b1;
        #1;
        chk("pc_src_nobr",  102, 32'(o_pc_src), 32'h0);

        drain();

        // Reset asserted mid-cycle clears the register immediately
        @(posedge i_clk);
        #3 i_rst = 1'b0;
        #1 chk_zero(200);
        m_rd = '0; m_alu = '0; m_wr = '0; m_wb = '0; m_mis = 1'b0;

        // A store presented while reset is held must not reach memory
        @(negedge i_clk);
        i_enable = 1'b1; i_alu_result = 32'h10; i_dato2 = 32'h0BADF00D;
        i_ctrl_mem = CM_WR; i_mem_size = 2'b10;
        @(posedge i_clk);
        #1 chk_zero(201);
        @(negedge i_clk);
        i_enable = 1'b0; i_ctrl_mem = CM_NONE;
        i_rst = 1'b1;

        drive(1, 32'h10, 32'h0, CM_RD, 2'b10, 0, 32'hDEAD55EF, 0);
        drive(1, 32'h20, 32'h0, CM_RD, 2'b10, 0, 32'hA5A5A5A5, 0);

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
